servo_pwm_gen: RTL and testbench

Dual-channel servo pulse generator sitting directly downstream of the line-follower steering FSM. It converts the two 8-bit speed commands (left/right wheel, units of 10 µs pulse width, 0 = no pulse) into standard 50 Hz servo PWM waveforms on two output pins. Commands are sampled once per frame so a pulse is never truncated or stretched mid-period.

---
 rtl/servo_pwm_gen.sv | 138 +++++++++++++
 tb/tb_servo_pwm_gen.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// servo_pwm_gen: dual-channel 50 Hz servo PWM generator.
// Each frame is FRAME_UNITS units long, and each unit is UNIT_TICKS clocks.
// The 8-bit commands (pulse width in units, 0 = no pulse, clamped to
// MAX_CMD) are sampled only at frame boundaries, so a pulse is never
// truncated or stretched in the middle of a frame.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-low reset
//   enable      1 = generate frames; 0 = outputs low, counters held at 0
//   servo_l     left command, pulse = servo_l * UNIT_TICKS cycles
//   servo_r     right command, same encoding
//   pwm_l       left PWM pin (registered)
//   pwm_r       right PWM pin (registered)
//   frame_start one-cycle strobe on the first cycle of each frame
//   busy        high while a frame is running
module servo_pwm_gen #(
   parameter int unsigned UNIT_TICKS  = 1000,
   parameter int unsigned FRAME_UNITS = 2000,
   parameter int unsigned MAX_CMD     = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] servo_l,
   input  logic [7:0] servo_r,
   output logic       pwm_l,
   output logic       pwm_r,
   output logic       frame_start,
   output logic       busy
);

   localparam int unsigned PW = $clog2(UNIT_TICKS);
   localparam int unsigned UW = $clog2(FRAME_UNITS);

   localparam logic [PW-1:0] PRESC_LAST = PW'(UNIT_TICKS - 1);
   localparam logic [UW-1:0] UNIT_LAST  = UW'(FRAME_UNITS - 1);
   localparam logic [7:0]    CMD_MAX    = 8'(MAX_CMD);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t        r_state;
   logic [PW-1:0] r_presc;
   logic [UW-1:0] r_unit;
   logic [7:0]    r_lat_l;
   logic [7:0]    r_lat_r;

   state_t        w_state_nx;
   logic [PW-1:0] w_presc_nx;
   logic [UW-1:0] w_unit_nx;
   logic [7:0]    w_lat_l_nx;
   logic [7:0]    w_lat_r_nx;
   logic          w_run_nx;
   logic          w_fs_nx;
   logic          w_pwm_l_nx;
   logic          w_pwm_r_nx;
   logic [7:0]    w_clamp_l;
   logic [7:0]    w_clamp_r;

   // Command clamp, applied whenever a command is latched
   assign w_clamp_l = (servo_l > CMD_MAX) ? CMD_MAX : servo_l;
   assign w_clamp_r = (servo_r > CMD_MAX) ? CMD_MAX : servo_r;

   // Next-state logic for the counters, latched commands and strobe
   always_comb begin
      w_state_nx = r_state;
      w_presc_nx = r_presc;
      w_unit_nx  = r_unit;
      w_lat_l_nx = r_lat_l;
      w_lat_r_nx = r_lat_r;
      w_fs_nx    = 1'b0;

      if (r_state == S_IDLE) begin
         w_presc_nx = '0;
         w_unit_nx  = '0;
         if (enable) begin
            w_state_nx = S_RUN;
            w_lat_l_nx = w_clamp_l;
            w_lat_r_nx = w_clamp_r;
            w_fs_nx    = 1'b1;
         end
      end else begin
         if (!enable) begin
            // Abort immediately; latched values are kept but unused
            w_state_nx = S_IDLE;
            w_presc_nx = '0;
            w_unit_nx  = '0;
         end else if (r_presc == PRESC_LAST) begin
            w_presc_nx = '0;
            if (r_unit == UNIT_LAST) begin
               // Frame boundary: restart and resample commands
               w_unit_nx  = '0;
               w_lat_l_nx = w_clamp_l;
               w_lat_r_nx = w_clamp_r;
               w_fs_nx    = 1'b1;
            end else begin
               w_unit_nx = r_unit + UW'(1);
            end
         end else begin
            w_presc_nx = r_presc + PW'(1);
         end
      end

      w_run_nx   = (w_state_nx == S_RUN);
      // Pins are computed from next-state values so they rise with frame_start
      w_pwm_l_nx = w_run_nx & (w_unit_nx < UW'(w_lat_l_nx));
      w_pwm_r_nx = w_run_nx & (w_unit_nx < UW'(w_lat_r_nx));
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_presc     <= '0;
         r_unit      <= '0;
         r_lat_l     <= '0;
         r_lat_r     <= '0;
         pwm_l       <= 1'b0;
         pwm_r       <= 1'b0;
         frame_start <= 1'b0;
         busy        <= 1'b0;
      end else begin
         r_state     <= w_state_nx;
         r_presc     <= w_presc_nx;
         r_unit      <= w_unit_nx;
         r_lat_l     <= w_lat_l_nx;
         r_lat_r     <= w_lat_r_nx;
         pwm_l       <= w_pwm_l_nx;
         pwm_r       <= w_pwm_r_nx;
         frame_start <= w_fs_nx;
         busy        <= w_run_nx;
      end
   end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Testbench for servo_pwm_gen: a monitor measures every completed frame
// (period, high time per pin, pin level on the frame_start cycle), and the
// test tasks push the expected frame descriptions and compare them in order.
module tb_servo_pwm_gen;

   localparam int UT    = 4;
   localparam int FU    = 300;
   localparam int MC    = 250;
   localparam int FRAME = UT * FU;

   typedef struct packed {
      int   period;
      int   hi_l;
      int   hi_r;
      logic l0;
      logic r0;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [7:0] servo_l;
   logic [7:0] servo_r;
   logic       pwm_l;
   logic       pwm_r;
   logic       frame_start;
   logic       busy;

   int n_pass  = 0;
   int n_total = 0;

   frame_t exp_q[$];
   frame_t meas_q[$];

   servo_pwm_gen #(
      .UNIT_TICKS (UT),
      .FRAME_UNITS(FU),
      .MAX_CMD    (MC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .enable     (enable),
      .servo_l    (servo_l),
      .servo_r    (servo_r),
      .pwm_l      (pwm_l),
      .pwm_r      (pwm_r),
      .frame_start(frame_start),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Frame monitor: a frame completes when the next frame_start arrives;
   // frames cut short by disable or reset are discarded.
   int   m_cyc = 0;
   int   m_hl  = 0;
   int   m_hr  = 0;
   logic m_l0  = 1'b0;
   logic m_r0  = 1'b0;
   bit   m_in  = 1'b0;

   always @(negedge clk) begin
      if (frame_start === 1'b1) begin
         if (m_in) meas_q.push_back(frame_t'{m_cyc, m_hl, m_hr, m_l0, m_r0});
         m_in  = 1'b1;
         m_cyc = 1;
         m_hl  = (pwm_l === 1'b1) ? 1 : 0;
         m_hr  = (pwm_r === 1'b1) ? 1 : 0;
         m_l0  = pwm_l;
         m_r0  = pwm_r;
      end else if (busy !== 1'b1) begin
         m_in = 1'b0;
      end else if (m_in) begin
         m_cyc++;
         if (pwm_l === 1'b1) m_hl++;
         if (pwm_r === 1'b1) m_hr++;
      end
   end

   // Expected frame from the commands in force at the boundary
   function automatic frame_t mk(input int l, input int r);
      int cl = (l > MC) ? MC : l;
      int cr = (r > MC) ? MC : r;
      return frame_t'{FRAME, cl * UT, cr * UT, logic'(cl != 0), logic'(cr != 0)};
   endfunction

   task automatic wait_fs(input string nm);
      bit seen = 1'b0;
      for (int i = 0; i < FRAME + 10 && !seen; i++) begin
         @(negedge clk); #1;
         if (frame_start === 1'b1) seen = 1'b1;
      end
      n_total++;
      if (!seen) $display("FAIL %s: frame_start not seen within %0d cycles", nm, FRAME + 10);
      else n_pass++;
   endtask

   task automatic test_reset();
      rst = 1'b0; enable = 1'b0; servo_l = 8'd0; servo_r = 8'd0;
      repeat (3) @(negedge clk);
      #1;
      n_total++;
      if ({pwm_l, pwm_r, frame_start, busy} !== 4'b0000)
         $display("FAIL reset_outputs: got %b want 0000", {pwm_l, pwm_r, frame_start, busy});
      else n_pass++;
      rst = 1'b1;
      repeat (5) @(negedge clk);
      #1;
      n_total++;
      if ({pwm_l, pwm_r, frame_start, busy} !== 4'b0000)
         $display("FAIL idle_no_enable: got %b want 0000", {pwm_l, pwm_r, frame_start, busy});
      else n_pass++;
   endtask

   task automatic test_basic();
      servo_l = 8'd155; servo_r = 8'd137; enable = 1'b1;
      @(negedge clk); #1;
      n_total++;
      if ({frame_start, busy, pwm_l, pwm_r} !== 4'b1111)
         $display("FAIL enable_latency: got %b want 1111", {frame_start, busy, pwm_l, pwm_r});
      else n_pass++;
      exp_q.push_back(mk(155, 137));   // F1
      exp_q.push_back(mk(155, 137));   // F2
      wait_fs("basic_f2");
   endtask

   task automatic test_stop();
      frame_t got, e;
      servo_l = 8'd0; servo_r = 8'd0;
      exp_q.push_back(mk(0, 0));       // F3
      wait_fs("stop_f3");
      n_total++;
      if ({pwm_l, pwm_r} !== 2'b00)
         $display("FAIL stop_no_pulse: got %b want 00", {pwm_l, pwm_r});
      else n_pass++;
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (meas_q.size() == 0 || exp_q.size() == 0)
            $display("FAIL frame_basic: measured %0d expected %0d queued", meas_q.size(), exp_q.size());
         else begin
            got = meas_q.pop_front(); e = exp_q.pop_front();
            if (got !== e)
               $display("FAIL frame_basic: got per=%0d l=%0d r=%0d l0=%b r0=%b want per=%0d l=%0d r=%0d l0=%b r0=%b",
                        got.period, got.hi_l, got.hi_r, got.l0, got.r0, e.period, e.hi_l, e.hi_r, e.l0, e.r0);
            else n_pass++;
         end
      end
   endtask

   task automatic test_mid_change();
      frame_t got, e;
      servo_l = 8'd155; servo_r = 8'd137;
      exp_q.push_back(mk(155, 137));   // F4
      wait_fs("mid_f4");
      for (int k = 0; k < 1; k++) begin
         n_total++;
         if (meas_q.size() == 0 || exp_q.size() == 0)
            $display("FAIL frame_stop: measured %0d expected %0d queued", meas_q.size(), exp_q.size());
         else begin
            got = meas_q.pop_front(); e = exp_q.pop_front();
            if (got !== e)
               $display("FAIL frame_stop: got per=%0d l=%0d r=%0d l0=%b r0=%b want per=%0d l=%0d r=%0d l0=%b r0=%b",
                        got.period, got.hi_l, got.hi_r, got.l0, got.r0, e.period, e.hi_l, e.hi_r, e.l0, e.r0);
            else n_pass++;
         end
      end
      repeat (99) @(negedge clk);
      #1;
      servo_l = 8'd0;
      n_total++;
      if (pwm_l !== 1'b1) $display("FAIL mid_pulse_high: got %b want 1", pwm_l);
      else n_pass++;
      exp_q.push_back(mk(0, 137));     // F5
      wait_fs("mid_f5");
      n_total++;
      if (pwm_l !== 1'b0) $display("FAIL next_frame_low: got %b want 0", pwm_l);
      else n_pass++;
      for (int k = 0; k < 1; k++) begin
         n_total++;
         if (meas_q.size() == 0 || exp_q.size() == 0)
            $display("FAIL frame_mid_change: measured %0d expected %0d queued", meas_q.size(), exp_q.size());
         else begin
            got = meas_q.pop_front(); e = exp_q.pop_front();
            if (got !== e)
               $display("FAIL frame_mid_change: got per=%0d l=%0d r=%0d l0=%b r0=%b want per=%0d l=%0d r=%0d l0=%b r0=%b",
                        got.period, got.hi_l, got.hi_r, got.l0, got.r0, e.period, e.hi_l, e.hi_r, e.l0, e.r0);
            else n_pass++;
         end
      end
   endtask

   task automatic test_clamp();
      frame_t got, e;
      servo_r = 8'd255;
      exp_q.push_back(mk(0, 255));     // F6
      wait_fs("clamp_f6");
      wait_fs("clamp_f7");
      for (int k = 0; k < 2; k++) begin
         n_total++;
         if (meas_q.size() == 0 || exp_q.size() == 0)
            $display("FAIL frame_clamp: measured %0d expected %0d queued", meas_q.size(), exp_q.size());
         else begin
            got = meas_q.pop_front(); e = exp_q.pop_front();
            if (got !== e)
               $display("FAIL frame_clamp: got per=%0d l=%0d r=%0d l0=%b r0=%b want per=%0d l=%0d r=%0d l0=%b r0=%b",
                        got.period, got.hi_l, got.hi_r, got.l0, got.r0, e.period, e.hi_l, e.hi_r, e.l0, e.r0);
            else n_pass++;
         end
      end
   endtask

   task automatic test_disable();
      frame_t got, e;
      int fs_seen = 0;
      repeat (299) @(negedge clk);
      #1;
      n_total++;
      if (pwm_r !== 1'b1) $display("FAIL pre_disable_high: got %b want 1", pwm_r);
      else n_pass++;
      enable = 1'b0;
      @(negedge clk); #1;
      n_total++;
      if ({pwm_l, pwm_r, busy, frame_start} !== 4'b0000)
         $display("FAIL disable_next_cycle: got %b want 0000", {pwm_l, pwm_r, busy, frame_start});
      else n_pass++;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk); #1;
         if (frame_start !== 1'b0 || busy !== 1'b0 || pwm_r !== 1'b0) fs_seen++;
      end
      n_total++;
      if (fs_seen != 0) $display("FAIL idle_quiet: got %0d active cycles want 0", fs_seen);
      else n_pass++;
      servo_l = 8'd155; servo_r = 8'd137; enable = 1'b1;
      @(negedge clk); #1;
      n_total++;
      if ({frame_start, busy, pwm_l, pwm_r} !== 4'b1111)
         $display("FAIL reenable: got %b want 1111", {frame_start, busy, pwm_l, pwm_r});
      else n_pass++;
      exp_q.push_back(mk(155, 137));   // G1
      wait_fs("reenable_g2");
      for (int k = 0; k < 1; k++) begin
         n_total++;
         if (meas_q.size() == 0 || exp_q.size() == 0)
            $display("FAIL frame_reenable: measured %0d expected %0d queued", meas_q.size(), exp_q.size());
         else begin
            got = meas_q.pop_front(); e = exp_q.pop_front();
            if (got !== e)
               $display("FAIL frame_reenable: got per=%0d l=%0d r=%0d l0=%b r0=%b want per=%0d l=%0d r=%0d l0=%b r0=%b",
                        got.period, got.hi_l, got.hi_r, got.l0, got.r0, e.period, e.hi_l, e.hi_r, e.l0, e.r0);
            else n_pass++;
         end
      end
   endtask

   task automatic test_async_reset();
      frame_t got, e;
      repeat (50) @(negedge clk);
      @(posedge clk); #2;
      n_total++;
      if ({pwm_l, pwm_r, busy} !== 3'b111)
         $display("FAIL pre_reset_high: got %b want 111", {pwm_l, pwm_r, busy});
      else n_pass++;
      rst = 1'b0;
      #1;
      n_total++;
      if ({pwm_l, pwm_r, busy} !== 3'b000)
         $display("FAIL async_reset: got %b want 000", {pwm_l, pwm_r, busy});
      else n_pass++;
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk); #1;
      n_total++;
      if ({frame_start, busy, pwm_l, pwm_r} !== 4'b1111)
         $display("FAIL post_reset_first_frame: got %b want 1111", {frame_start, busy, pwm_l, pwm_r});
      else n_pass++;
      exp_q.push_back(mk(155, 137));   // H1
      wait_fs("post_reset_h2");
      for (int k = 0; k < 1; k++) begin
         n_total++;
         if (meas_q.size() == 0 || exp_q.size() == 0)
            $display("FAIL frame_post_reset: measured %0d expected %0d queued", meas_q.size(), exp_q.size());
         else begin
            got = meas_q.pop_front(); e = exp_q.pop_front();
            if (got !== e)
               $display("FAIL frame_post_reset: got per=%0d l=%0d r=%0d l0=%b r0=%b want per=%0d l=%0d r=%0d l0=%b r0=%b",
                        got.period, got.hi_l, got.hi_r, got.l0, got.r0, e.period, e.hi_l, e.hi_r, e.l0, e.r0);
            else n_pass++;
         end
      end
      n_total++;
      if (exp_q.size() != 0 || meas_q.size() != 0)
         $display("FAIL scoreboard_drained: got exp=%0d meas=%0d want 0/0", exp_q.size(), meas_q.size());
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stop();
      test_mid_change();
      test_clamp();
      test_disable();
      test_async_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
